// File: rtl/signal_gen_ctrl.sv
// Waveform table address sequencer: steps a phase accumulator through one of
// several sample tables at a programmable rate, counting periods per burst.
module signal_gen_ctrl #(
  parameter int NB_ADDR  = 10,
  parameter int NB_SEL   = 2,
  parameter int NB_DIV   = 8,
  parameter int NB_BURST = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic [NB_SEL-1:0]         i_sel,
  input  logic [NB_ADDR-NB_SEL-1:0] i_step,
  input  logic [NB_DIV-1:0]         i_div,
  input  logic [NB_BURST-1:0]       i_nper,
  output logic [NB_ADDR-1:0]        o_addr,
  output logic                      o_valid,
  output logic                      o_period,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int NB_PH = NB_ADDR - NB_SEL;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, next_state;

  logic [NB_SEL-1:0]   sel_q,   sel_d;
  logic [NB_PH-1:0]    step_q,  step_d;
  logic [NB_DIV-1:0]   div_q,   div_d;
  logic [NB_BURST-1:0] nper_q,  nper_d;
  logic [NB_PH-1:0]    phase,   phase_d;
  logic [NB_DIV-1:0]   div_cnt, div_cnt_d;
  logic [NB_BURST-1:0] per_cnt, per_cnt_d;
  logic [NB_ADDR-1:0]  addr_q,  addr_d;
  logic                valid_q, valid_d;
  logic                period_q, period_d;
  logic                done_q,  done_d;

  logic [NB_PH-1:0]    step_fix;
  logic [NB_PH-1:0]    phase_sum;
  logic                carry;
  logic [NB_BURST-1:0] per_inc;
  logic                tick;
  logic                wrap;
  logic                burst_end;

  // Event decode: sample ticks, phase carry and the final wrap of a burst
  always_comb begin
    step_fix           = (i_step == '0) ? NB_PH'(1) : i_step;
    {carry, phase_sum} = {1'b0, phase} + {1'b0, step_q};
    per_inc            = per_cnt + NB_BURST'(1);
    tick               = (state == RUN) && (div_cnt == div_q);
    wrap               = tick && carry;
    burst_end          = wrap && (nper_q != '0) && (per_inc == nper_q);
  end

  // State register; reset drops straight to IDLE with no exit pulse
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: start leaves IDLE, stop or the last wrap of a burst returns
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (i_start) next_state = RUN;
      RUN:  if (i_stop || burst_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and output next values; stop takes priority over any wrap
  always_comb begin
    sel_d     = sel_q;
    step_d    = step_q;
    div_d     = div_q;
    nper_d    = nper_q;
    phase_d   = phase;
    div_cnt_d = div_cnt;
    per_cnt_d = per_cnt;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    period_d  = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          sel_d     = i_sel;
          step_d    = step_fix;
          div_d     = i_div;
          nper_d    = i_nper;
          phase_d   = '0;
          div_cnt_d = '0;
          per_cnt_d = '0;
          addr_d    = {i_sel, {NB_PH{1'b0}}};
          valid_d   = 1'b1;
        end
      end
      RUN: begin
        if (i_stop) begin
          done_d = 1'b1;
        end else if (tick) begin
          div_cnt_d = '0;
          if (wrap) per_cnt_d = per_inc;
          if (burst_end) begin
            done_d = 1'b1;
          end else begin
            phase_d  = phase_sum;
            valid_d  = 1'b1;
            period_d = wrap;
            if (wrap) begin
              sel_d  = i_sel;
              step_d = step_fix;
              div_d  = i_div;
              addr_d = {i_sel, phase_sum};
            end else begin
              addr_d = {sel_q, phase_sum};
            end
          end
        end else begin
          div_cnt_d = div_cnt + NB_DIV'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs, cleared by reset
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sel_q    <= '0;
      step_q   <= '0;
      div_q    <= '0;
      nper_q   <= '0;
      phase    <= '0;
      div_cnt  <= '0;
      per_cnt  <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      period_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      step_q   <= step_d;
      div_q    <= div_d;
      nper_q   <= nper_d;
      phase    <= phase_d;
      div_cnt  <= div_cnt_d;
      per_cnt  <= per_cnt_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

  assign o_addr   = addr_q;
  assign o_valid  = valid_q;
  assign o_period = period_q;
  assign o_done   = done_q;
  assign o_busy   = (state == RUN);

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Self-checking bench for signal_gen_ctrl using an arithmetic burst model.
module tb_signal_gen_ctrl;

  logic       i_clock;
  logic       i_reset;
  logic       i_start;
  logic       i_stop;
  logic [1:0] i_sel;
  logic [7:0] i_step;
  logic [7:0] i_div;
  logic [7:0] i_nper;
  logic [9:0] o_addr;
  logic       o_valid;
  logic       o_period;
  logic       o_busy;
  logic       o_done;

  int tests_run = 0;
  int tests_failed = 0;

  signal_gen_ctrl #(
    .NB_ADDR(10), .NB_SEL(2), .NB_DIV(8), .NB_BURST(8)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_sel(i_sel), .i_step(i_step), .i_div(i_div), .i_nper(i_nper),
    .o_addr(o_addr), .o_valid(o_valid), .o_period(o_period),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Free-running clock
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Model of one burst: sample k shows up on RUN cycle k*(div+1) at phase
  // k*step mod 256; the cumulative carry count floor(k*step/256) gives the
  // wraps, and the burst ends on the sample that would make it reach nper.
  task automatic run_case(input logic [1:0] sel, input logic [7:0] step,
                          input logic [7:0] div, input logic [7:0] nper,
                          input int stop_cycle, input string name);
    longint t = 256;
    longint p, st, endc, d, kk;
    logic [7:0]  ph;
    logic [13:0] exp_v, obs_v;
    logic        ev, eperiod;
    p  = longint'(div) + 1;
    st = (step == 8'd0) ? 1 : longint'(step);
    if (nper != 8'd0) endc = ((longint'(nper) * t + st - 1) / st) * p;
    else endc = 64'd1 << 40;
    d = endc;
    if (stop_cycle >= 0 && longint'(stop_cycle) + 1 < d) d = longint'(stop_cycle) + 1;
    @(negedge i_clock);
    i_start = 1'b1; i_stop = 1'b0;
    i_sel = sel; i_step = step; i_div = div; i_nper = nper;
    for (longint c = 0; c <= d + 1; c++) begin
      @(negedge i_clock);
      if (c < d) begin
        kk = c / p;
        ph = 8'((kk * st) % t);
        ev = ((c % p) == 0);
        eperiod = ev && (kk > 0) && (((kk * st) / t) != (((kk - 1) * st) / t));
        exp_v = {1'b1, ev, eperiod, 1'b0, sel, ph};
      end else begin
        kk = (d - 1) / p;
        ph = 8'((kk * st) % t);
        exp_v = {1'b0, 1'b0, 1'b0, (c == d), sel, ph};
      end
      obs_v = {o_busy, o_valid, o_period, o_done, o_addr};
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL %s cycle %0d: busy/valid/period/done/addr got %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                 name, c, obs_v[13], obs_v[12], obs_v[11], obs_v[10], obs_v[9:0],
                 exp_v[13], exp_v[12], exp_v[11], exp_v[10], exp_v[9:0]);
      end
      i_stop  = (c == longint'(stop_cycle));
      i_start = (c < d) ? 1'($urandom_range(1, 0)) : 1'b0;
      if (c == 0) i_start = 1'b0;
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_start = 1'b1; i_stop = 1'b0;
    i_sel = 2'd3; i_step = 8'd7; i_div = 8'd0; i_nper = 8'd0;
    repeat (3) @(negedge i_clock);
    tests_run++;
    if ({o_busy, o_valid, o_period, o_done, o_addr} !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got busy=%b valid=%b period=%b done=%b addr=%h expected all 0",
               o_busy, o_valid, o_period, o_done, o_addr);
    end
    i_start = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clock);
    tests_run++;
    if ({o_busy, o_valid, o_done, o_addr} !== 13'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_idle: got busy=%b valid=%b done=%b addr=%h expected all 0",
               o_busy, o_valid, o_done, o_addr);
    end
  endtask

  task automatic test_stop_idle();
    @(negedge i_clock);
    i_stop = 1'b1;
    @(negedge i_clock);
    i_stop = 1'b0;
    @(negedge i_clock);
    tests_run++;
    if ({o_busy, o_valid, o_period, o_done, o_addr} !== {4'b0000, 10'h2FF}) begin
      tests_failed++;
      $display("[TB] FAIL stop_in_idle: got busy=%b valid=%b period=%b done=%b addr=%h expected 0/0/0/0/2ff",
               o_busy, o_valid, o_period, o_done, o_addr);
    end
  endtask

  task automatic test_sel_change();
    logic [9:0] exp_addr [0:6];
    logic       exp_per  [0:6];
    exp_addr = '{10'h100, 10'h180, 10'h100, 10'h180, 10'h300, 10'h380, 10'h380};
    exp_per  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge i_clock);
    i_start = 1'b1; i_sel = 2'd1; i_step = 8'd128; i_div = 8'd0; i_nper = 8'd0;
    for (int c = 0; c < 7; c++) begin
      @(negedge i_clock);
      i_start = 1'b0;
      tests_run++;
      if (o_addr !== exp_addr[c] || o_period !== exp_per[c] || o_valid !== (c < 6) ||
          o_done !== (c == 6) || o_busy !== (c < 6)) begin
        tests_failed++;
        $display("[TB] FAIL sel_change cycle %0d: addr=%h period=%b valid=%b done=%b busy=%b expected addr=%h period=%b valid=%b done=%b busy=%b",
                 c, o_addr, o_period, o_valid, o_done, o_busy,
                 exp_addr[c], exp_per[c], (c < 6), (c == 6), (c < 6));
      end
      if (c == 2) i_sel = 2'd3;
      i_stop = (c == 5);
    end
    i_stop = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic test_reset_during_run();
    @(negedge i_clock);
    i_start = 1'b1; i_sel = 2'd1; i_step = 8'd5; i_div = 8'd1; i_nper = 8'd0;
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (6) @(negedge i_clock);
    tests_run++;
    if (o_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_run_busy: busy=%b expected 1", o_busy);
    end
    i_reset = 1'b0; i_stop = 1'b1; i_start = 1'b1;
    @(negedge i_clock);
    tests_run++;
    if ({o_busy, o_valid, o_period, o_done, o_addr} !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_during_run: got busy=%b valid=%b period=%b done=%b addr=%h expected all 0",
               o_busy, o_valid, o_period, o_done, o_addr);
    end
    i_start = 1'b0; i_stop = 1'b0; i_reset = 1'b1;
    @(negedge i_clock);
    tests_run++;
    if ({o_busy, o_done} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_done: busy=%b done=%b expected 0/0", o_busy, o_done);
    end
    run_case(2'd3, 8'd0, 8'd0, 8'd1, -1, "step_zero");
  endtask

  task automatic test_random();
    logic [1:0] sel;
    logic [7:0] step, div, nper;
    int         stop_cycle;
    for (int n = 0; n < 12; n++) begin
      sel  = 2'($urandom_range(3, 0));
      step = 8'($urandom_range(255, 0));
      div  = 8'($urandom_range(3, 0));
      nper = 8'($urandom_range(3, 0));
      stop_cycle = -1;
      if (nper == 8'd0 || $urandom_range(3, 0) == 0) stop_cycle = int'($urandom_range(300, 0));
      run_case(sel, step, div, nper, stop_cycle, "random");
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    run_case(2'd2, 8'd1, 8'd0, 8'd1, -1, "burst_step1");
    test_stop_idle();
    run_case(2'd0, 8'd64, 8'd3, 8'd2, -1, "burst_div3");
    run_case(2'd0, 8'd64, 8'd3, 8'd2, 15, "stop_on_wrap");
    test_sel_change();
    test_reset_during_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
